// File: rtl/var_range_table.sv
// Per-variable clause-range table: start/end/valid per variable, registered multi-port reads
// with write-first bypass, in-place extend, swept bulk clear, error pulse and occupancy count.
module var_range_table #(
  parameter int unsigned NUM_VARS     = 16,
  parameter int unsigned IDX_BITS     = 8,
  parameter int unsigned NUM_RD_PORTS = 2,
  localparam int unsigned VAR_BITS    = $clog2(NUM_VARS)
) (
  input  logic                             clock,
  input  logic                             reset_n,
  input  logic                             wr_en,
  input  logic [VAR_BITS-1:0]              wr_var,
  input  logic [IDX_BITS-1:0]              wr_start,
  input  logic [IDX_BITS-1:0]              wr_end,
  input  logic                             ext_en,
  input  logic [VAR_BITS-1:0]              ext_var,
  input  logic [NUM_RD_PORTS-1:0]          rd_req,
  input  logic [NUM_RD_PORTS*VAR_BITS-1:0] rd_var,
  output logic [NUM_RD_PORTS-1:0]          rd_valid,
  output logic [NUM_RD_PORTS-1:0]          rd_hit,
  output logic [NUM_RD_PORTS*IDX_BITS-1:0] rd_start,
  output logic [NUM_RD_PORTS*IDX_BITS-1:0] rd_end,
  input  logic                             clear_req,
  output logic                             busy,
  output logic                             err,
  output logic [VAR_BITS:0]                valid_count
);

  typedef enum logic {StIdle, StClear} state_e;

  state_e                state_q;
  logic [VAR_BITS-1:0]   ptr_q;
  logic [NUM_VARS-1:0]   valid_q, valid_d;
  logic [IDX_BITS-1:0]   start_q [NUM_VARS];
  logic [IDX_BITS-1:0]   start_d [NUM_VARS];
  logic [IDX_BITS-1:0]   end_q   [NUM_VARS];
  logic [IDX_BITS-1:0]   end_d   [NUM_VARS];

  logic                  clearing;
  logic                  wr_in_range, ext_valid, ext_sat;
  logic                  wr_ok, ext_ok, ext_drop, err_d;
  logic [VAR_BITS:0]     count_d;
  logic [NUM_RD_PORTS-1:0]          rd_hit_d;
  logic [NUM_RD_PORTS*IDX_BITS-1:0] rd_start_d, rd_end_d;

  assign clearing = (state_q == StClear);

  // Index decode by comparison keeps out-of-range indices harmless when NUM_VARS is not 2^n.
  always_comb begin
    wr_in_range = 1'b0;
    ext_valid   = 1'b0;
    ext_sat     = 1'b0;
    for (int unsigned i = 0; i < NUM_VARS; i++) begin
      if (wr_var == VAR_BITS'(i)) wr_in_range = 1'b1;
      if (ext_var == VAR_BITS'(i)) begin
        ext_valid = valid_q[i];
        ext_sat   = &end_q[i];
      end
    end
    wr_ok    = wr_en && !clearing && wr_in_range && (wr_start <= wr_end);
    // A write to the same variable supersedes the extend without flagging an error.
    ext_drop = wr_en && !clearing && (wr_var == ext_var);
    ext_ok   = ext_en && !clearing && !ext_drop && ext_valid && !ext_sat;
    err_d    = (wr_en && !wr_ok) || (ext_en && !ext_drop && !ext_ok);
  end

  always_comb begin
    valid_d = valid_q;
    count_d = '0;
    for (int unsigned i = 0; i < NUM_VARS; i++) begin
      start_d[i] = start_q[i];
      end_d[i]   = end_q[i];
      if (clearing && ptr_q == VAR_BITS'(i)) begin
        valid_d[i] = 1'b0;
        start_d[i] = '0;
        end_d[i]   = '0;
      end
      if (ext_ok && ext_var == VAR_BITS'(i)) end_d[i] = end_q[i] + IDX_BITS'(1);
      if (wr_ok && wr_var == VAR_BITS'(i)) begin
        valid_d[i] = 1'b1;
        start_d[i] = wr_start;
        end_d[i]   = wr_end;
      end
      count_d = count_d + {{VAR_BITS{1'b0}}, valid_d[i]};
    end
  end

  // Reads look at the post-edge table contents (write-first bypass).
  always_comb begin
    rd_hit_d   = '0;
    rd_start_d = '0;
    rd_end_d   = '0;
    for (int unsigned p = 0; p < NUM_RD_PORTS; p++) begin
      for (int unsigned i = 0; i < NUM_VARS; i++) begin
        if (rd_req[p] && rd_var[p*VAR_BITS +: VAR_BITS] == VAR_BITS'(i) && valid_d[i]) begin
          rd_hit_d[p]                   = 1'b1;
          rd_start_d[p*IDX_BITS +: IDX_BITS] = start_d[i];
          rd_end_d[p*IDX_BITS +: IDX_BITS]   = end_d[i];
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      busy        <= 1'b0;
      valid_q     <= '0;
      err         <= 1'b0;
      valid_count <= '0;
      rd_valid    <= '0;
      rd_hit      <= '0;
      rd_start    <= '0;
      rd_end      <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (clear_req) begin
            state_q <= StClear;
            ptr_q   <= '0;
            busy    <= 1'b1;
          end
        end
        StClear: begin
          if (ptr_q == VAR_BITS'(NUM_VARS - 1)) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            busy    <= 1'b0;
          end else begin
            ptr_q <= ptr_q + VAR_BITS'(1);
          end
        end
      endcase
      valid_q     <= valid_d;
      err         <= err_d;
      valid_count <= count_d;
      rd_valid    <= rd_req;
      rd_hit      <= rd_hit_d;
      rd_start    <= rd_start_d;
      rd_end      <= rd_end_d;
    end
  end

  // Range data needs no reset: it is only observed through a valid bit.
  always_ff @(posedge clock) begin
    start_q <= start_d;
    end_q   <= end_d;
  end

endmodule

// File: tb/tb_var_range_table.sv
// Randomised bench for var_range_table against a per-cycle behavioural table model.
module tb_var_range_table;

  localparam int NV = 16;
  localparam int IB = 8;
  localparam int NP = 2;
  localparam int VB = 4;
  localparam int IMAX = (1 << IB) - 1;

  logic            clock = 1'b0;
  logic            reset_n = 1'b0;
  logic            wr_en, ext_en, clear_req;
  logic [VB-1:0]   wr_var, ext_var;
  logic [IB-1:0]   wr_start, wr_end;
  logic [NP-1:0]   rd_req;
  logic [NP*VB-1:0] rd_var;
  logic [NP-1:0]   rd_valid, rd_hit;
  logic [NP*IB-1:0] rd_start, rd_end;
  logic            busy, err;
  logic [VB:0]     valid_count;

  var_range_table #(.NUM_VARS(NV), .IDX_BITS(IB), .NUM_RD_PORTS(NP)) dut (
    .clock(clock), .reset_n(reset_n),
    .wr_en(wr_en), .wr_var(wr_var), .wr_start(wr_start), .wr_end(wr_end),
    .ext_en(ext_en), .ext_var(ext_var),
    .rd_req(rd_req), .rd_var(rd_var),
    .rd_valid(rd_valid), .rd_hit(rd_hit), .rd_start(rd_start), .rd_end(rd_end),
    .clear_req(clear_req), .busy(busy), .err(err), .valid_count(valid_count)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model: the table as plain arrays plus the number of sweep cycles remaining.
  bit m_valid [NV];
  int m_start [NV];
  int m_end   [NV];
  int clear_left;
  int exp_rv [NP], exp_hit [NP], exp_s [NP], exp_e [NP];
  int exp_busy, exp_err, exp_count;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NV; i++) m_valid[i] = 1'b0;
    clear_left = 0;
    for (int p = 0; p < NP; p++) begin
      exp_rv[p] = 0; exp_hit[p] = 0; exp_s[p] = 0; exp_e[p] = 0;
    end
    exp_busy = 0; exp_err = 0; exp_count = 0;
  endtask

  task automatic model_step();
    bit was_busy;
    bit rej;
    int v;
    was_busy = (clear_left > 0);
    rej = 1'b0;
    if (ext_en) begin
      if (was_busy) rej = 1'b1;
      else if (!(wr_en && wr_var == ext_var)) begin
        if (!m_valid[ext_var] || m_end[ext_var] == IMAX) rej = 1'b1;
        else m_end[ext_var] = m_end[ext_var] + 1;
      end
    end
    if (wr_en) begin
      if (was_busy || wr_start > wr_end) rej = 1'b1;
      else begin
        m_valid[wr_var] = 1'b1;
        m_start[wr_var] = wr_start;
        m_end[wr_var]   = wr_end;
      end
    end
    if (was_busy) begin
      m_valid[NV - clear_left] = 1'b0;
      clear_left--;
    end else if (clear_req) begin
      clear_left = NV;
    end
    exp_err   = rej;
    exp_busy  = (clear_left > 0);
    exp_count = 0;
    for (int i = 0; i < NV; i++) exp_count += m_valid[i];
    for (int p = 0; p < NP; p++) begin
      v = rd_var[p*VB +: VB];
      exp_rv[p]  = rd_req[p];
      exp_hit[p] = rd_req[p] && m_valid[v];
      exp_s[p]   = exp_hit[p] ? m_start[v] : 0;
      exp_e[p]   = exp_hit[p] ? m_end[v] : 0;
    end
  endtask

  task automatic check_outputs();
    for (int p = 0; p < NP; p++) begin
      check("rd_valid", rd_valid[p], exp_rv[p]);
      check("rd_hit",   rd_hit[p],   exp_hit[p]);
      check("rd_start", rd_start[p*IB +: IB], exp_s[p]);
      check("rd_end",   rd_end[p*IB +: IB],   exp_e[p]);
    end
    check("busy", busy, exp_busy);
    check("err", err, exp_err);
    check("valid_count", valid_count, exp_count);
  endtask

  task automatic idle();
    wr_en = 0; ext_en = 0; clear_req = 0; rd_req = '0;
    wr_var = '0; ext_var = '0; wr_start = '0; wr_end = '0; rd_var = '0;
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
    check_outputs();
  endtask

  task automatic do_write(input int v, input int s, input int e);
    wr_en = 1; wr_var = VB'(v); wr_start = IB'(s); wr_end = IB'(e);
  endtask

  task automatic do_read(input int p, input int v);
    rd_req[p] = 1'b1; rd_var[p*VB +: VB] = VB'(v);
  endtask

  task automatic release_reset();
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic read_all_miss();
    for (int v = 0; v < NV; v += 2) begin
      idle(); do_read(0, v); do_read(1, v + 1); tick();
      check("miss_hit", rd_hit, 0);
    end
  endtask

  initial begin
    idle();
    model_reset();
    #3;
    check_outputs();
    release_reset();

    // Reads after reset miss on both ports.
    idle(); do_read(0, 0); do_read(1, 15); tick();
    idle(); do_read(0, 15); do_read(1, 0); tick();
    check("rst_rd_valid", rd_valid, 2'b11);
    check("rst_rd_hit", rd_hit, 2'b00);

    // Write with same-edge bypass read.
    idle(); do_write(3, 10, 20); do_read(0, 3); tick();
    check("bypass_start", rd_start[IB-1:0], 10);
    check("bypass_end", rd_end[IB-1:0], 20);
    check("bypass_count", valid_count, 1);

    // Extend three times, then read.
    for (int k = 0; k < 3; k++) begin idle(); ext_en = 1; ext_var = 3; tick(); end
    idle(); do_read(1, 3); tick();
    check("ext_end", rd_end[2*IB-1:IB], 23);

    // Saturated and invalid extends.
    idle(); do_write(5, 0, 255); tick();
    idle(); ext_en = 1; ext_var = 5; do_read(0, 5); tick();
    check("sat_err", err, 1);
    check("sat_end", rd_end[IB-1:0], 255);
    idle(); ext_en = 1; ext_var = 7; tick();
    check("inv_ext_err", err, 1);

    // Reversed range, then write/extend collision on the same variable.
    idle(); do_write(4, 9, 8); do_read(0, 4); tick();
    check("rev_err", err, 1);
    check("rev_hit", rd_hit[0], 0);
    idle(); do_write(3, 1, 2); ext_en = 1; ext_var = 3; do_read(0, 3); tick();
    check("coll_err", err, 0);
    check("coll_end", rd_end[IB-1:0], 2);

    // Bulk clear with a write attempted during the sweep.
    idle(); do_write(0, 1, 4); tick();
    idle(); do_write(9, 5, 5); tick();
    idle(); clear_req = 1; tick();
    for (int k = 0; k < NV; k++) begin
      idle();
      if (k == 4) do_write(1, 0, 0);
      if (k == 8) clear_req = 1;
      check("busy_during", busy, 1);
      tick();
    end
    check("busy_after", busy, 0);
    check("count_after", valid_count, 0);
    read_all_miss();

    // Reset in the middle of a sweep.
    idle(); do_write(2, 3, 4); tick();
    idle(); clear_req = 1; tick();
    idle();
    for (int k = 0; k < 6; k++) tick();
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check("rst_mid_busy", busy, 0);
    check_outputs();
    release_reset();
    read_all_miss();
    check("rst_mid_count", valid_count, 0);

    // Randomised traffic.
    for (int n = 0; n < 3000; n++) begin
      idle();
      if ($urandom_range(0, 2) == 0) begin
        wr_en = 1; wr_var = VB'($urandom); wr_start = IB'($urandom);
        case ($urandom_range(0, 3))
          0: wr_end = IB'($urandom);
          1: wr_end = IB'(IMAX);
          default: wr_end = (int'(wr_start) + 4 > IMAX) ? IB'(IMAX) : wr_start + IB'(4);
        endcase
      end
      if ($urandom_range(0, 2) == 0) begin
        ext_en = 1;
        ext_var = ($urandom_range(0, 3) == 0) ? wr_var : VB'($urandom);
      end
      rd_req = NP'($urandom);
      rd_var = (NP*VB)'($urandom);
      clear_req = ($urandom_range(0, 60) == 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/var_range_table.md
Name: var_range_table

Overview:
- Parametrised per-variable clause-range table: for every variable, stores the start and end index of that variable's clause list in the clause table, plus a valid bit.
- Successor of the single-port start/end table, adding:
  - multiple registered read ports
  - write-first bypass
  - in-place range extension
  - a swept bulk-clear state machine
  - error flagging and occupancy count
- Sits between the clause loader (writes, extends) and the BCP/implication engines (reads).

Parameters:
- NUM_VARS, 16: number of table entries. Must be ≥ 2. VAR_BITS = $clog2(NUM_VARS) is a derived localparam.
- IDX_BITS, 8: width of a clause-table index.
- NUM_RD_PORTS, 2: number of independent read ports.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- wr_en  in  1  write request.
- wr_var  in  VAR_BITS  entry to write.
- wr_start  in  IDX_BITS  range start.
- wr_end  in  IDX_BITS  range end, inclusive.
- ext_en  in  1  extend request: end index of an existing entry +1.
- ext_var  in  VAR_BITS  entry to extend.
- rd_req  in  NUM_RD_PORTS  per-port read request.
- rd_var  in  NUM_RD_PORTS*VAR_BITS  per-port variable. Port p occupies slice [p*VAR_BITS +: VAR_BITS].
- rd_valid  out  NUM_RD_PORTS  response valid, one cycle after rd_req.
- rd_hit  out  NUM_RD_PORTS  entry was valid.
- rd_start  out  NUM_RD_PORTS*IDX_BITS  per-port start.
- rd_end  out  NUM_RD_PORTS*IDX_BITS  per-port end.
- clear_req  in  1  start bulk clear.
- busy  out  1  clear in progress.
- err  out  1  one-cycle pulse on a rejected write or extend.
- valid_count  out  VAR_BITS+1  number of valid entries.

Behaviour:
- Reset (reset_n low, asynchronous):
  - all valid bits 0
  - FSM to IDLE, clear pointer 0
  - busy, err, rd_valid, rd_hit, rd_start, rd_end all 0; valid_count 0
  - Data storage need not be reset.
  - Reset mid-clear aborts the sweep immediately.
- FSM states: IDLE and CLEAR.
  - IDLE → CLEAR when clear_req=1; ptr set to 0. busy=1 from the next cycle.
  - In CLEAR, each cycle zeroes entry[ptr] (data 0, valid 0) and increments ptr.
  - After the cycle that clears ptr=NUM_VARS-1, returns to IDLE. busy is high for exactly NUM_VARS cycles.
  - clear_req while in CLEAR is ignored.
- Write (wr_en=1, busy=0): at the edge, entry[wr_var] ← {wr_start, wr_end} and valid ← 1.
  - If wr_start > wr_end: no update; err=1 next cycle.
- Extend (ext_en=1, busy=0, valid[ext_var]=1, end≠2^IDX_BITS-1): end ← end+1; start unchanged.
  - If the entry is invalid or end is saturated: no update; err=1 next cycle.
- Simultaneous write and extend:
  - Same variable: the write wins; the extend is dropped silently (no err).
  - Different variables: both take effect.
- Write or extend while busy: dropped; err=1 next cycle.
- Read:
  - rd_req[p] is sampled at the edge; the next cycle rd_valid[p]=1.
  - Outputs reflect the table state after that same edge's write or extend (write-first bypass), including the clear of that entry in the same cycle.
  - rd_hit = valid bit. If the entry is invalid, rd_start/rd_end = 0.
  - When rd_valid[p]=0, that port's rd_hit, rd_start and rd_end are 0.
  - Ports are fully independent; multiple ports may read the same variable.
- valid_count:
  - Registered; equals the popcount of the valid bits after each edge.
  - Increments only on a write to a previously invalid entry.
  - Decrements as the sweep clears valid entries.
- err is registered, one cycle wide. Multiple rejected requests in one cycle still produce a single pulse.
- Indices wider than NUM_VARS-1 (when NUM_VARS is not a power of 2): the request is treated as rejected (err) for wr/ext; a read returns hit=0.

Test Plan (NUM_VARS=16, IDX_BITS=8, NUM_RD_PORTS=2):
- Reset, then read vars 0 and 15 on both ports → rd_valid=2'b11, rd_hit=0, start/end=0, valid_count=0.
- Write var 3 = {10,20}; the same edge, port 0 reads var 3 → next cycle rd_hit[0]=1, start=10, end=20 (bypass); valid_count=1.
- Extend var 3 three times → end=23. Write var 5 = {0,255}, then extend var 5 → err pulse, end stays 255. Extend invalid var 7 → err pulse.
- Write var 4 = {9,8} → err pulse, var 4 stays invalid. Same-cycle write var 3 = {1,2} with extend var 3 → entry {1,2}, no err.
- Fill 4 entries, assert clear_req → busy high for 16 cycles; valid_count falls to 0; a write during busy gives err; afterwards all reads miss.
- Assert reset_n low at clear cycle 6 → busy=0 immediately; after release, all entries invalid and valid_count=0.
